nxr_cmp_pipe: RTL and testbench
===============================

// Module: nxr_cmp_pipe
// PURPOSE
//  Parametrised, registered successor to the 2-input XNOR cell: WIDTH-bit bitwise XNOR of i0/i1
//  with a per-bit mask, giving a masked all-equal flag.
//  Tracks runs of consecutive equal samples and raises a sticky hit after THRESH equal samples.
//  Used as the pattern/lock detector in the StdCellLib demo datapaths; built only from library cells.
// PARAMETERS
//  WIDTH   8  compared word width (>=1)
//  CNT_W   4  run counter width (>=2)
//  THRESH  3  equal-sample run length that sets hit (1..2**CNT_W-1)
// PORTS
//  ck       in   1      clock, rising edge
//  nrst     in   1      asynchronous active-low reset
//  i_vld    in   1      i0/i1/mask sample valid this cycle
//  i0       in   WIDTH  operand A
//  i1       in   WIDTH  operand B
//  mask     in   WIDTH  1 = bit participates in eq; 0 = bit ignored
//  i_clr    in   1      synchronous clear of counter and hit state
//  nq       out  WIDTH  registered ~(i0 ^ i1) of last valid sample
//  eq       out  1      registered &(nq | ~mask) of last valid sample
//  o_vld    out  1      nq/eq updated this cycle
//  run_cnt  out  CNT_W  consecutive valid equal samples, saturating
//  hit      out  1      sticky: run reached THRESH
//  par      out  1      registered ^nq (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (nrst=0, async): nq=0, eq=0, o_vld=0, run_cnt=0, hit=0, par=0, state=IDLE.
//  - Latency 1: a sample with i_vld=1 at edge k appears on nq/eq/par with o_vld=1 after edge k.
//  - Cycles with i_vld=0: nq/eq/par hold; o_vld=0; counter and state hold (gaps do not break a run).
//  - mask all-zero: eq=1 for every valid sample.
//  - FSM states IDLE, RUN, LOCK, evaluated on the registered eq, i.e. the cycle after the sample:
//    IDLE: o_vld&eq -> run_cnt=1, go RUN (go LOCK directly if THRESH==1).
//    RUN:  o_vld&eq -> run_cnt+1 (saturate at 2**CNT_W-1); at run_cnt+1==THRESH set hit, go LOCK.
//          o_vld&~eq -> run_cnt=0, go IDLE.
//    LOCK: hit=1 held; run_cnt keeps counting/saturating on eq; o_vld&~eq -> run_cnt=0, stays LOCK.
//  - i_clr=1: next edge run_cnt=0, hit=0, state=IDLE; wins over any simultaneous count/transition.
//    The datapath still captures a valid input sample in that same cycle.
//  - hit leaves LOCK only via i_clr or nrst.
//  - nrst asserted mid-run: all state cleared immediately.
//    First valid sample after release is treated as a fresh run.
//  - All arithmetic unsigned; run_cnt never wraps.
// CONFIGURATION
//  NXR_CMP_PARITY_EN defined: par = registered ^(~(i0^i1)) of each valid sample, same timing as nq.
//  Not defined: par tied to 0, no parity logic; port list unchanged.
// TESTING
//  1. WIDTH=8, mask=FF, i0=A5,i1=A5, i_vld=1 -> next cycle nq=FF, eq=1, o_vld=1; par=0 if _EN.
//  2. i0=A5,i1=A4, mask=FF -> nq=FE, eq=0; repeat with mask=FE -> eq=1.
//  3. Three equal samples with i_vld=1,0,1,0,1 -> run_cnt 1,1,2,2,3; hit=1 after third, state LOCK.
//  4. LOCK, then unequal sample -> run_cnt=0, hit stays 1; i_clr=1 -> hit=0, IDLE.
//  5. i_clr=1 with an equal valid sample on the same edge in RUN -> run_cnt=0, nq/eq still updated.
//  6. 20 equal samples with CNT_W=4 -> run_cnt saturates at 15.
//     Pull nrst low mid-run -> all outputs 0 at once.

Source files
------------

// File: rtl/nxr_cmp_pipe.sv
// Registered masked XNOR comparator with a run-length lock detector (IDLE/RUN/LOCK).
// Optional parity output enabled by defining NXR_CMP_PARITY_EN.
module nxr_cmp_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned THRESH = 3
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] mask,
  input  logic             i_clr,
  output logic [WIDTH-1:0] nq,
  output logic             eq,
  output logic             o_vld,
  output logic [CNT_W-1:0] run_cnt,
  output logic             hit,
  output logic             par
);

  typedef enum logic [1:0] {StIdle, StRun, StLock} state_e;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] ThreshCnt = CNT_W'(THRESH);

  logic [WIDTH-1:0] nq_d, nq_q;
  logic             eq_d, eq_q;
  logic             vld_q;

  assign nq_d = ~(i0 ^ i1);
  assign eq_d = &(nq_d | ~mask);

  // Datapath: captures every valid sample, including one that arrives alongside i_clr.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      nq_q  <= '0;
      eq_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= i_vld;
      if (i_vld) begin
        nq_q <= nq_d;
        eq_q <= eq_d;
      end
    end
  end

`ifdef NXR_CMP_PARITY_EN
  logic par_q;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      par_q <= 1'b0;
    end else if (i_vld) begin
      par_q <= ^nq_d;
    end
  end

  assign par = par_q;
`else
  assign par = 1'b0;
`endif

  assign nq    = nq_q;
  assign eq    = eq_q;
  assign o_vld = vld_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hit_q, hit_d;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  // FSM acts on the registered result, one cycle behind the sample; i_clr overrides it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    if (i_clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      hit_d   = 1'b0;
    end else if (vld_q) begin
      unique case (state_q)
        StIdle: begin
          if (eq_q) begin
            cnt_d = CNT_W'(1);
            if (THRESH == 1) begin
              hit_d   = 1'b1;
              state_d = StLock;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (eq_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == ThreshCnt) begin
              hit_d   = 1'b1;
              state_d = StLock;
            end
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        StLock: begin
          cnt_d = eq_q ? cnt_inc : '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          hit_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    run_cnt = cnt_q;
    hit     = hit_q;
  end

endmodule

// File: tb/tb_nxr_cmp_pipe.sv
// Scoreboard bench for nxr_cmp_pipe: directed scenarios then random stimulus against
// a run-length reference model.
module tb_nxr_cmp_pipe;

  localparam int W      = 8;
  localparam int CW     = 4;
  localparam int THRESH = 3;
  localparam int CMAX   = (1 << CW) - 1;

  typedef struct packed {
    logic [W-1:0] nq;
    logic         eq;
    logic         par;
  } exp_t;

  logic          ck = 1'b0;
  logic          nrst = 1'b0;
  logic          i_vld = 1'b0;
  logic [W-1:0]  i0 = '0;
  logic [W-1:0]  i1 = '0;
  logic [W-1:0]  mask = '0;
  logic          i_clr = 1'b0;
  logic [W-1:0]  nq;
  logic          eq;
  logic          o_vld;
  logic [CW-1:0] run_cnt;
  logic          hit;
  logic          par;

  nxr_cmp_pipe #(
    .WIDTH (W),
    .CNT_W (CW),
    .THRESH(THRESH)
  ) dut (
    .ck     (ck),
    .nrst   (nrst),
    .i_vld  (i_vld),
    .i0     (i0),
    .i1     (i1),
    .mask   (mask),
    .i_clr  (i_clr),
    .nq     (nq),
    .eq     (eq),
    .o_vld  (o_vld),
    .run_cnt(run_cnt),
    .hit    (hit),
    .par    (par)
  );

  always #5 ck = ~ck;

  exp_t exp_q[$];
  int   m_run = 0;
  bit   m_hit = 1'b0;
  bit   pend_v = 1'b0;
  bit   pend_eq = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  bit   done = 1'b0;
  bit   end_chk = 1'b0;
  exp_t last = '0;

  function automatic exp_t expect_of(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m);
    exp_t e;
    e.nq = ~(a ^ b);
    e.eq = ((a & m) == (b & m));
`ifdef NXR_CMP_PARITY_EN
    e.par = ^e.nq;
`else
    e.par = 1'b0;
`endif
    return e;
  endfunction

  // Reference: run = consecutive equal valid samples, counted one cycle after the
  // result appears; hit = run reached THRESH since the last clear.
  always @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      m_run  = 0;
      m_hit  = 1'b0;
      pend_v = 1'b0;
      exp_q.delete();
    end else begin
      if (i_clr) begin
        m_run = 0;
        m_hit = 1'b0;
      end else if (pend_v) begin
        if (pend_eq) m_run = (m_run >= CMAX) ? CMAX : m_run + 1;
        else         m_run = 0;
        if (m_run >= THRESH) m_hit = 1'b1;
      end
      pend_v = i_vld;
      if (i_vld) begin
        exp_t e;
        e = expect_of(i0, i1, mask);
        pend_eq = e.eq;
        exp_q.push_back(e);
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge ck) begin
    if (!nrst) begin
      last = '0;
      chk("reset nq", 32'(nq), 0);
      chk("reset eq", 32'(eq), 0);
      chk("reset o_vld", 32'(o_vld), 0);
      chk("reset run_cnt", 32'(run_cnt), 0);
      chk("reset hit", 32'(hit), 0);
      chk("reset par", 32'(par), 0);
    end else begin
      chk("o_vld", 32'(o_vld), 32'(pend_v));
      chk("run_cnt", 32'(run_cnt), 32'(m_run));
      chk("hit", 32'(hit), 32'(m_hit));
      if (o_vld) begin
        if (exp_q.size() == 0) chk("unexpected o_vld", 32'(o_vld), 0);
        else last = exp_q.pop_front();
      end
      chk("nq", 32'(nq), 32'(last.nq));
      chk("eq", 32'(eq), 32'(last.eq));
      chk("par", 32'(par), 32'(last.par));
      if (done && !end_chk) begin
        chk("queue drained", 32'(exp_q.size()), 0);
        end_chk = 1'b1;
      end
    end
  end

  task automatic step(bit v, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m, bit c);
    @(negedge ck);
    i_vld = v;
    i0    = a;
    i1    = b;
    mask  = m;
    i_clr = c;
  endtask

  task automatic rand_step();
    logic [W-1:0] a, b, m;
    int r;
    a = W'($urandom);
    r = $urandom_range(0, 3);
    if (r < 2)       b = a;
    else if (r == 2) b = a ^ (W'(1) << $urandom_range(0, W - 1));
    else             b = W'($urandom);
    r = $urandom_range(0, 3);
    if (r == 1)      m = '0;
    else if (r == 2) m = W'($urandom);
    else             m = '1;
    step($urandom_range(0, 3) != 0, a, b, m, $urandom_range(0, 29) == 0);
  endtask

  initial begin
    repeat (2) @(negedge ck);
    #1 nrst = 1'b1;
    // Basic compare, mask handling, all-zero mask.
    step(1, 8'hA5, 8'hA5, 8'hFF, 0);
    step(1, 8'hA5, 8'hA4, 8'hFF, 0);
    step(1, 8'hA5, 8'hA4, 8'hFE, 0);
    step(1, 8'h12, 8'hED, 8'h00, 0);
    step(0, 8'h00, 8'h00, 8'hFF, 1);
    step(0, 8'h00, 8'h00, 8'hFF, 0);
    // Run through gaps to lock, then unequal sample, then clear.
    for (int k = 0; k < 5; k++) step(k % 2 == 0, 8'h3C, 8'h3C, 8'hFF, 0);
    repeat (2) step(0, 8'h00, 8'h00, 8'hFF, 0);
    step(1, 8'h00, 8'h01, 8'hFF, 0);
    repeat (2) step(0, 8'h00, 8'h00, 8'hFF, 0);
    step(0, 8'h00, 8'h00, 8'hFF, 1);
    step(0, 8'h00, 8'h00, 8'hFF, 0);
    // Clear coinciding with an equal sample while in RUN.
    step(1, 8'h77, 8'h77, 8'hFF, 0);
    step(1, 8'h77, 8'h77, 8'hFF, 0);
    step(1, 8'h66, 8'h66, 8'hFF, 1);
    step(0, 8'h00, 8'h00, 8'hFF, 0);
    repeat (2) step(0, 8'h00, 8'h00, 8'hFF, 0);
    // Saturation, then asynchronous reset mid-run.
    repeat (20) step(1, 8'h5A, 8'h5A, 8'hFF, 0);
    step(0, 8'h00, 8'h00, 8'hFF, 0);
    @(posedge ck);
    #2 nrst = 1'b0;
    repeat (2) @(negedge ck);
    #1 nrst = 1'b1;
    repeat (600) rand_step();
    repeat (3) step(0, 8'h00, 8'h00, 8'hFF, 0);
    done = 1'b1;
    repeat (3) @(negedge ck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
